unsort_restore: RTL and testbench

//   Inverse of insert_sort: takes a sorted value list and its sorted_positions list, and scatters

---
 rtl/unsort_restore_if.sv | 36 +++
 rtl/unsort_restore.sv | 115 +++++++++++
 tb/tb_unsort_restore.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/unsort_restore_if.sv
// Handshake and data bundle between an unsort_restore block and its requester.
// master drives the request; slave (the restore block) returns status and the restored list.
interface unsort_restore_if #(
    parameter int unsigned INPUTVALS      = 16,
    parameter int unsigned INPUTBITWIDTHS = 32
);
    localparam int unsigned PW = $clog2(INPUTVALS) + 1;

    logic                                      start;
    logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  sorted_in;
    logic [INPUTVALS-1:0][PW-1:0]              positions_in;
    logic                                      busy;
    logic                                      done;
    logic                                      error;
    logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  restored;

    modport master (
        output start,
        output sorted_in,
        output positions_in,
        input  busy,
        input  done,
        input  error,
        input  restored
    );

    modport slave (
        input  start,
        input  sorted_in,
        input  positions_in,
        output busy,
        output done,
        output error,
        output restored
    );
endinterface

// File: rtl/unsort_restore.sv
// Scatters a sorted value list back to its original order, one element per clock,
// using the sort's position list and flagging any position that is out of range or repeated.
module unsort_restore #(
    parameter int unsigned INPUTVALS      = 16,
    parameter int unsigned INPUTBITWIDTHS = 32
) (
    input logic              clk,
    input logic              reset,
    unsort_restore_if.slave  bus
);
    localparam int unsigned N  = INPUTVALS;
    localparam int unsigned W  = INPUTBITWIDTHS;
    localparam int unsigned PW = $clog2(N) + 1;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StScatter = 2'b01
    } state_e;

    state_e                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [N-1:0]               seen_q, seen_d;
    logic [N-1:0][W-1:0]        val_q, val_d;
    logic [N-1:0][PW-1:0]       pos_q, pos_d;
    logic [N-1:0][W-1:0]        work_q, work_d;
    logic [N-1:0][W-1:0]        restored_q, restored_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic [PW-1:0]              p;
    logic [IW-1:0]              p_idx;
    logic                       p_ok;

    always_comb begin
        p     = pos_q[idx_q];
        p_idx = p[IW-1:0];
        p_ok  = (p < PW'(N));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seen_d     = seen_q;
        val_d      = val_q;
        pos_d      = pos_q;
        work_d     = work_q;
        restored_d = restored_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    val_d   = bus.sorted_in;
                    pos_d   = bus.positions_in;
                    seen_d  = '0;
                    work_d  = '0;
                    idx_d   = '0;
                    state_d = StScatter;
                end
            end
            StScatter: begin
                // Range is checked first so seen_q is only indexed with a legal position.
                if (!p_ok || seen_q[p_idx]) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    work_d[p_idx] = val_q[idx_q];
                    seen_d[p_idx] = 1'b1;
                    if (idx_q == IW'(N - 1)) begin
                        restored_d = work_d;
                        done_d     = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                error_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            seen_q     <= '0;
            val_q      <= '0;
            pos_q      <= '0;
            work_q     <= '0;
            restored_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seen_q     <= seen_d;
            val_q      <= val_d;
            pos_q      <= pos_d;
            work_q     <= work_d;
            restored_q <= restored_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.busy     = (state_q == StScatter);
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.restored = restored_q;
endmodule

// File: tb/tb_unsort_restore.sv
// Directed bench for unsort_restore (N=4, W=8): an operation-level model predicts busy/done/error
// and restored every cycle, and literal expectations pin the model for each scenario.
module tb_unsort_restore;
    localparam int N = 4;
    localparam int W = 8;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    unsort_restore_if #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) bus ();

    unsort_restore #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation-level model: on an accepted start it resolves the whole op at once (outcome,
    // busy length, result) and then just counts down the cycles until the pulse.
    int                  m_left = 0;
    bit                  m_bad = 1'b0;
    logic [N-1:0][W-1:0] m_result = '0;
    logic                m_busy = 1'b0, m_done = 1'b0, m_error = 1'b0;
    logic [N-1:0][W-1:0] m_restored = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_left = 0; m_busy = 0; m_done = 0; m_error = 0; m_restored = '0;
            end else begin
                m_done = 0;
                m_error = 0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_bad) m_error = 1;
                        else begin
                            m_done = 1;
                            m_restored = m_result;
                        end
                    end
                end else if (bus.start) begin
                    bit [N-1:0] seen;
                    int badk;
                    seen = '0; m_bad = 0; badk = 0; m_result = '0;
                    for (int k = 0; k < N; k++) begin
                        int pk;
                        pk = int'(bus.positions_in[k]);
                        if (!m_bad) begin
                            if (pk >= N || seen[pk]) begin
                                m_bad = 1; badk = k;
                            end else begin
                                seen[pk] = 1;
                                m_result[pk] = bus.sorted_in[k];
                            end
                        end
                    end
                    m_left = m_bad ? badk + 1 : N;
                end
                m_busy = (m_left > 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("busy", 32'(bus.busy), 32'(m_busy));
                check("done", 32'(bus.done), 32'(m_done));
                check("error", 32'(bus.error), 32'(m_error));
                check("restored", bus.restored, m_restored);
                if (bus.done && bus.error) check("done_error_exclusive", 32'd1, 32'd0);
            end
        end
    end

    task automatic do_op(input logic [N-1:0][W-1:0] v, input logic [N-1:0][PW-1:0] p,
                         output int busy_n, output int done_n, output int err_n);
        busy_n = 0; done_n = 0; err_n = 0;
        @(negedge clk);
        bus.sorted_in = v; bus.positions_in = p; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble inputs to confirm they were captured at the start edge.
        bus.sorted_in = '1; bus.positions_in = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_n++;
            if (bus.error) err_n++;
            @(negedge clk);
        end
    endtask

    int b, d, e;
    int last_done;

    initial begin
        bus.start = 1'b0; bus.sorted_in = '0; bus.positions_in = '0;
        #1 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {bus.busy, bus.done, bus.error}, 32'd0);
        end
        check("idle_restored", bus.restored, 32'd0);

        // 2: valid permutation {2,0,3,1}
        do_op({8'd40, 8'd30, 8'd20, 8'd10}, {3'd1, 3'd3, 3'd0, 3'd2}, b, d, e);
        check("t2_busy_cycles", b, 4);
        check("t2_done_pulses", d, 1);
        check("t2_error_pulses", e, 0);
        check("t2_restored", bus.restored, {8'd30, 8'd10, 8'd40, 8'd20});

        // 3: duplicate position {1,1,0,2}
        do_op({8'd4, 8'd3, 8'd2, 8'd1}, {3'd2, 3'd0, 3'd1, 3'd1}, b, d, e);
        check("t3_busy_cycles", b, 2);
        check("t3_error_pulses", e, 1);
        check("t3_done_pulses", d, 0);
        check("t3_restored_kept", bus.restored, {8'd30, 8'd10, 8'd40, 8'd20});

        // 4: out-of-range position {0,1,4,2}
        do_op({8'd9, 8'd8, 8'd7, 8'd6}, {3'd2, 3'd4, 3'd1, 3'd0}, b, d, e);
        check("t4_busy_cycles", b, 3);
        check("t4_error_pulses", e, 1);
        check("t4_done_pulses", d, 0);
        check("t4_restored_kept", bus.restored, {8'd30, 8'd10, 8'd40, 8'd20});

        // 5: start held high, identity permutation
        @(negedge clk);
        bus.sorted_in = {8'd8, 8'd7, 8'd6, 8'd5};
        bus.positions_in = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.start = 1'b1;
        b = 0; d = 0; last_done = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.busy) b++;
            if (bus.done) begin
                if (last_done >= 0) check("t5_done_period", i - last_done, 5);
                last_done = i;
                d++;
            end
        end
        bus.start = 1'b0;
        check("t5_done_pulses", d, 3);
        check("t5_busy_cycles", b, 12);
        check("t5_restored", bus.restored, {8'd8, 8'd7, 8'd6, 8'd5});
        repeat (6) @(negedge clk);

        // 6: reset two cycles into scatter
        @(negedge clk);
        bus.sorted_in = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.positions_in = {3'd1, 3'd3, 3'd0, 3'd2};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("t6_busy_before_reset", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_reset_outputs", {bus.busy, bus.done, bus.error}, 32'd0);
        check("t6_reset_restored", bus.restored, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op({8'd40, 8'd30, 8'd20, 8'd10}, {3'd1, 3'd3, 3'd0, 3'd2}, b, d, e);
        check("t6_done_pulses", d, 1);
        check("t6_restored", bus.restored, {8'd30, 8'd10, 8'd40, 8'd20});

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
